// File: rtl/approx_loa_adder_pipe.sv
// Pipelined lower-part-OR approximate adder with a valid/ready stream
// interface and an online error monitor (sample count, violation count,
// max error, sticky violation flag).
//
// Handshake: a beat transfers on a port in any cycle where valid & ready
// are both high at the rising clock edge. A producer holds valid and its
// data stable until the transfer. out_* never change while
// out_valid & ~out_ready. in_ready depends on out_ready only, never on
// in_valid.
module approx_loa_adder_pipe #(
  parameter int WIDTH       = 2,
  parameter int APPROX_BITS = 1,
  parameter int ET          = 0,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [WIDTH:0]     out_err,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_cnt,
  output logic [CNT_W-1:0]   stat_viol,
  output logic [WIDTH:0]     stat_max,
  output logic               viol_flag
);

  // Index of the top approximated bit; clamped so it stays legal when no
  // bits are approximated (the carry is forced to 0 in that case).
  localparam int KM1 = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  // Ones in the APPROX_BITS low positions of a WIDTH+1 bit word.
  localparam logic [WIDTH:0] LO_MASK = {(WIDTH+1){1'b1}} >> (WIDTH + 1 - APPROX_BITS);

  // Stage 1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic               s1_mode_q, s1_mode_d;
  // Stage 2 registers
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic [WIDTH:0]     err_q, err_d;
  // Statistics
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   viol_q, viol_d;
  logic [WIDTH:0]     max_q, max_d;
  logic               flag_q, flag_d;

  // Datapath intermediates
  logic [WIDTH:0]     a_ext, b_ext;
  logic [WIDTH:0]     exact_sum, hi_sum, approx_sum, calc_sum, calc_err;
  logic               cin;
  // Flow control
  logic               s2_load, s1_moves, s1_load, accept, is_viol;

  // Stage advance: S2 frees up when empty or being drained; S1 drains into S2.
  always_comb begin
    s2_load  = ~s2_valid_q | out_ready;
    s1_moves = s1_valid_q & s2_load;
    in_ready = ~s1_valid_q | s1_moves;
    s1_load  = in_valid & in_ready;
    accept   = s2_valid_q & out_ready;
  end

  // Exact and lower-part-OR sums from the stage-1 operands, plus |error|.
  always_comb begin
    a_ext      = {1'b0, s1_a_q};
    b_ext      = {1'b0, s1_b_q};
    exact_sum  = a_ext + b_ext;
    cin        = (APPROX_BITS > 0) ? (s1_a_q[KM1] & s1_b_q[KM1]) : 1'b0;
    hi_sum     = (a_ext >> APPROX_BITS) + (b_ext >> APPROX_BITS) + {{WIDTH{1'b0}}, cin};
    approx_sum = (hi_sum << APPROX_BITS) | ((a_ext | b_ext) & LO_MASK);
    calc_sum   = s1_mode_q ? approx_sum : exact_sum;
    calc_err   = (calc_sum >= exact_sum) ? (calc_sum - exact_sum) : (exact_sum - calc_sum);
  end

  // Next state of the two pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    err_d      = err_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_load) begin
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_mode_d = in_mode;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d = calc_sum;
        err_d = calc_err;
      end
    end
  end

  // Statistics update on accepted results; clear takes priority.
  always_comb begin
    is_viol = accept & (32'(err_q) > 32'(ET));
    cnt_d   = cnt_q;
    viol_d  = viol_q;
    max_d   = max_q;
    flag_d  = flag_q;
    if (stat_clr) begin
      cnt_d  = '0;
      viol_d = '0;
      max_d  = '0;
      flag_d = 1'b0;
    end else if (accept) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      if (is_viol) begin
        viol_d = (&viol_q) ? viol_q : viol_q + CNT_W'(1);
        flag_d = 1'b1;
      end
      if (err_q > max_q) begin
        max_d = err_q;
      end
    end
  end

  // State registers for pipeline and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      viol_q     <= '0;
      max_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      viol_q     <= viol_d;
      max_q      <= max_d;
      flag_q     <= flag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_err   = err_q;
  assign stat_cnt  = cnt_q;
  assign stat_viol = viol_q;
  assign stat_max  = max_q;
  assign viol_flag = flag_q;

endmodule

// File: tb/tb_approx_loa_adder_pipe.sv
// Bench for approx_loa_adder_pipe: WIDTH=2, APPROX_BITS=1, ET=0, with a
// second CNT_W=2 instance for counter saturation.
module tb_approx_loa_adder_pipe;

  typedef struct {
    logic       mode;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] sum;
    logic [2:0] err;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic       in_valid = 1'b0, in_ready, in_mode = 1'b0;
  logic [1:0] in_a = '0, in_b = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [2:0] out_sum, out_err, stat_max;
  logic       stat_clr = 1'b0, viol_flag;
  logic [15:0] stat_cnt, stat_viol;

  // saturation instance signals
  logic       in_valid2 = 1'b0, in_ready2, in_mode2 = 1'b1;
  logic [1:0] in_a2 = 2'd1, in_b2 = 2'd1;
  logic       out_valid2, out_ready2 = 1'b1;
  logic [2:0] out_sum2, out_err2, stat_max2;
  logic       stat_clr2 = 1'b0, viol_flag2;
  logic [1:0] stat_cnt2, stat_viol2;

  approx_loa_adder_pipe #(.WIDTH(2), .APPROX_BITS(1), .ET(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_viol(stat_viol),
    .stat_max(stat_max), .viol_flag(viol_flag)
  );

  approx_loa_adder_pipe #(.WIDTH(2), .APPROX_BITS(1), .ET(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_mode(in_mode2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sum(out_sum2), .out_err(out_err2),
    .stat_clr(stat_clr2), .stat_cnt(stat_cnt2), .stat_viol(stat_viol2),
    .stat_max(stat_max2), .viol_flag(viol_flag2)
  );

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  logic [5:0] exp_q[$];   // {sum, err}
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare accepted results in order, and check hold stability
  logic       hold_seen = 1'b0;
  logic [2:0] hold_sum, hold_err;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) begin
        if (hold_seen) begin
          check("hold_sum", out_sum, hold_sum);
          check("hold_err", out_err, hold_err);
        end
        hold_seen = 1'b1;
        hold_sum  = out_sum;
        hold_err  = out_err;
      end else begin
        hold_seen = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          check("out_sum", out_sum, e[5:3]);
          check("out_err", out_err, e[2:0]);
        end
      end
    end
  end

  // driver: present a beat and hold it until in_ready, then queue expectation
  task automatic send(input logic mode, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] sum, input logic [2:0] err);
    int n;
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else exp_q.push_back({sum, err});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
  endtask

  initial begin
    int n;
    // approx vectors, hand-computed for W=2, K=1
    vecs.push_back('{1'b1, 2'd1, 2'd1, 3'd3, 3'd1});
    vecs.push_back('{1'b1, 2'd3, 2'd3, 3'd7, 3'd1});
    vecs.push_back('{1'b1, 2'd2, 2'd1, 3'd3, 3'd0});
    vecs.push_back('{1'b1, 2'd3, 2'd1, 3'd5, 3'd1});
    vecs.push_back('{1'b1, 2'd2, 2'd2, 3'd4, 3'd0});
    vecs.push_back('{1'b1, 2'd0, 2'd0, 3'd0, 3'd0});
    vecs.push_back('{1'b1, 2'd1, 2'd2, 3'd3, 3'd0});
    vecs.push_back('{1'b1, 2'd3, 2'd2, 3'd5, 3'd0});

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_err", out_err, 0);
    check("rst_stat_cnt", stat_cnt, 0);
    check("rst_stat_viol", stat_viol, 0);
    check("rst_stat_max", stat_max, 0);
    check("rst_viol_flag", viol_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single approx beat: latency and violation stats
    send(1'b1, 2'd1, 2'd1, 3'd3, 3'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    drain();
    @(negedge clk);
    check("t1_stat_cnt", stat_cnt, 1);
    check("t1_stat_viol", stat_viol, 1);
    check("t1_viol_flag", viol_flag, 1);
    check("t1_stat_max", stat_max, 1);

    // all 16 exact pairs back-to-back
    @(posedge clk);
    #1;
    clear_stats();
    stall_cnt = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        send(1'b0, 2'(a), 2'(b), 3'(a + b), 3'd0);
      end
    end
    in_valid = 1'b0;
    check("exact_no_stall", stall_cnt, 0);
    drain();
    @(negedge clk);
    check("exact_stat_cnt", stat_cnt, 16);
    check("exact_stat_viol", stat_viol, 0);
    check("exact_stat_max", stat_max, 0);

    // approx table back-to-back
    @(posedge clk);
    #1;
    clear_stats();
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].err);
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("approx_stat_cnt", stat_cnt, 8);
    check("approx_stat_viol", stat_viol, 3);
    check("approx_stat_max", stat_max, 1);
    check("approx_viol_flag", viol_flag, 1);

    // backpressure: two beats fill the pipe, third stalls
    @(posedge clk);
    #1;
    clear_stats();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_a = 2'd1; in_b = 2'd2;
    exp_q.push_back({3'd3, 3'd0});
    @(posedge clk);
    #1;
    in_a = 2'd2; in_b = 2'd2;
    exp_q.push_back({3'd4, 3'd0});
    @(posedge clk);
    #1;
    in_a = 2'd3; in_b = 2'd3;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum", out_sum, 3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b0, 2'd3, 2'd3, 3'd6, 3'd0);
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("bp_stat_cnt", stat_cnt, 3);

    // clear on the same edge as accepting an err=1 beat
    @(posedge clk);
    #1;
    clear_stats();
    out_ready = 1'b0;
    send(1'b1, 2'd1, 2'd1, 3'd3, 3'd1);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("clr_wait_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_queue_empty", exp_q.size(), 0);
    check("clr_stat_cnt", stat_cnt, 0);
    check("clr_stat_viol", stat_viol, 0);
    check("clr_viol_flag", viol_flag, 0);
    check("clr_stat_max", stat_max, 0);

    // saturation on a CNT_W=2 instance: 5 violating beats
    @(posedge clk);
    #1;
    in_valid2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_stat_viol", stat_viol2, 3);
    check("sat_stat_cnt", stat_cnt2, 3);
    check("sat_viol_flag", viol_flag2, 1);

    // async reset with two beats in flight
    @(posedge clk);
    #1;
    send(1'b0, 2'd1, 2'd1, 3'd2, 3'd0);
    send(1'b0, 2'd2, 2'd1, 3'd3, 3'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_sum", out_sum, 0);
    check("arst_out_err", out_err, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_sat_viol", stat_viol2, 0);
    check("arst_sat_cnt", stat_cnt2, 0);
    check("arst_sat_flag", viol_flag2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_out", out_valid, 0);
    end
    check("post_rst_stat_cnt", stat_cnt, 0);

    // pipeline still works after reset
    @(posedge clk);
    #1;
    send(1'b1, 2'd3, 2'd1, 3'd5, 3'd1);
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("final_stat_cnt", stat_cnt, 1);
    check("final_stat_viol", stat_viol, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
